// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid slot so in_ready is registered and never
// combinationally depends on out_ready. Flush discards held entries and counts lossy flushes.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W      = 96,
  parameter int unsigned          CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter logic [DATA_W-1:0]    DATA_BUBBLE = DATA_W'(32'h0000_0033)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_r, nextState_s;
  logic [CTRL_W-1:0] outCtrl_r, outCtrl_s, skidCtrl_r, skidCtrl_s;
  logic [DATA_W-1:0] outData_r, outData_s, skidData_r, skidData_s;
  logic              inReady_r, inReady_s, outValid_r, outValid_s;
  logic [1:0]        occupancy_r, occupancy_s;
  logic [7:0]        dropCnt_r, dropCnt_s;
  logic              inFire_s, outFire_s;

  assign inFire_s  = in_valid & inReady_r;
  assign outFire_s = outValid_r & out_ready;

  // Next-state, next-entry and next-output computation
  always_comb begin
    nextState_s = state_r;
    outCtrl_s   = outCtrl_r;
    outData_s   = outData_r;
    skidCtrl_s  = skidCtrl_r;
    skidData_s  = skidData_r;
    dropCnt_s   = dropCnt_r;

    if (flush) begin
      nextState_s = EMPTY;
      outCtrl_s   = CTRL_BUBBLE;
      outData_s   = DATA_BUBBLE;
      skidCtrl_s  = {CTRL_W{1'b0}};
      skidData_s  = {DATA_W{1'b0}};
      if ((state_r != EMPTY) && (dropCnt_r != 8'd255)) dropCnt_s = dropCnt_r + 8'd1;
      else dropCnt_s = dropCnt_r;
    end else begin
      case (state_r)
        EMPTY: begin
          if (inFire_s) begin
            outCtrl_s   = in_ctrl;
            outData_s   = in_data;
            nextState_s = ONE;
          end else nextState_s = EMPTY;
        end
        ONE: begin
          if (inFire_s && outFire_s) begin
            outCtrl_s = in_ctrl;
            outData_s = in_data;
          end else if (inFire_s) begin
            skidCtrl_s  = in_ctrl;
            skidData_s  = in_data;
            nextState_s = FULL;
          end else if (outFire_s) begin
            // Payload data lingers after delivery; only control is bubbled.
            outCtrl_s   = CTRL_BUBBLE;
            nextState_s = EMPTY;
          end else nextState_s = ONE;
        end
        FULL: begin
          if (outFire_s) begin
            outCtrl_s   = skidCtrl_r;
            outData_s   = skidData_r;
            nextState_s = ONE;
          end else nextState_s = FULL;
        end
        default: begin
          nextState_s = EMPTY;
          outCtrl_s   = CTRL_BUBBLE;
          outData_s   = DATA_BUBBLE;
        end
      endcase
    end

    outValid_s = (nextState_s != EMPTY);
    inReady_s  = (nextState_s != FULL);
    case (nextState_s)
      EMPTY:   occupancy_s = 2'd0;
      ONE:     occupancy_s = 2'd1;
      FULL:    occupancy_s = 2'd2;
      default: occupancy_s = 2'd0;
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= EMPTY;
      outCtrl_r   <= CTRL_BUBBLE;
      outData_r   <= DATA_BUBBLE;
      skidCtrl_r  <= {CTRL_W{1'b0}};
      skidData_r  <= {DATA_W{1'b0}};
      inReady_r   <= 1'b1;
      outValid_r  <= 1'b0;
      occupancy_r <= 2'd0;
      dropCnt_r   <= 8'd0;
    end else begin
      state_r     <= nextState_s;
      outCtrl_r   <= outCtrl_s;
      outData_r   <= outData_s;
      skidCtrl_r  <= skidCtrl_s;
      skidData_r  <= skidData_s;
      inReady_r   <= inReady_s;
      outValid_r  <= outValid_s;
      occupancy_r <= occupancy_s;
      dropCnt_r   <= dropCnt_s;
    end
  end

  assign in_ready  = inReady_r;
  assign out_valid = outValid_r;
  assign out_ctrl  = outCtrl_r;
  assign out_data  = outData_r;
  assign occupancy = occupancy_r;
  assign drop_cnt  = dropCnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic,
// compared every cycle against a two-deep queue model of the stage.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 16;
  localparam logic [DW-1:0] BUB = 96'h0000_0000_0000_0000_0000_0033;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [7:0]    drop_cnt;

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int   numVectors = 0;
  int   numErrors  = 0;
  ent_t q[$];
  logic [DW-1:0] lastData = BUB;
  int   expDrop = 0;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numVectors++;
    if (got !== exp) begin
      numErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare all outputs against the queue model.
  task automatic checkAll(input string tag);
    checkVal({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
    checkVal({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
    checkVal({tag, ".occupancy"}, 128'(occupancy), 128'(q.size()));
    checkVal({tag, ".out_ctrl"},  128'(out_ctrl),  (q.size() > 0) ? 128'(q[0].c) : 128'd0);
    checkVal({tag, ".out_data"},  128'(out_data),  (q.size() > 0) ? 128'(q[0].d) : 128'(lastData));
    checkVal({tag, ".drop_cnt"},  128'(drop_cnt),  128'(expDrop));
  endtask

  // One clock: drive inputs, advance the model by the handshake rules, then check.
  task automatic step(input string tag, input logic iv, input logic [CW-1:0] ic,
                      input logic [DW-1:0] id, input logic ordy, input logic fl);
    bit   inF, outF;
    ent_t e;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    inF  = iv && (q.size() < 2);
    outF = ordy && (q.size() > 0);
    e.c = ic; e.d = id;
    @(posedge clk);
    if (fl) begin
      if (q.size() > 0 && expDrop < 255) expDrop++;
      q.delete();
      lastData = BUB;
    end else begin
      if (outF) void'(q.pop_front());
      if (inF) q.push_back(e);
      if (q.size() > 0) lastData = q[0].d;
    end
    #1;
    checkAll(tag);
  endtask

  initial begin
    // Reset state
    #12;
    checkAll("reset");
    @(negedge clk) reset = 1'b1;
    #1;

    // Streaming: one entry per cycle, latency 1
    for (int i = 1; i <= 10; i++) begin
      step("stream", 1'b1, 16'(i), 96'(i), 1'b1, 1'b0);
      checkVal("stream.data", 128'(out_data), 128'(i));
    end
    step("stream.drain", 1'b0, 16'd0, 96'd0, 1'b1, 1'b0);

    // Backpressure: A, B held, C refused; then ordered delivery
    step("bp.A", 1'b1, 16'hA, 96'hAAAA, 1'b0, 1'b0);
    step("bp.B", 1'b1, 16'hB, 96'hBBBB, 1'b0, 1'b0);
    step("bp.C", 1'b1, 16'hC, 96'hCCCC, 1'b0, 1'b0);
    checkVal("bp.full_occ", 128'(occupancy), 128'd2);
    checkVal("bp.head", 128'(out_data), 128'hAAAA);
    step("bp.relA", 1'b0, 16'h0, 96'h0, 1'b1, 1'b0);
    checkVal("bp.nextB", 128'(out_data), 128'hBBBB);
    step("bp.relB", 1'b1, 16'hC, 96'hCCCC, 1'b1, 1'b0);
    checkVal("bp.nextC", 128'(out_data), 128'hCCCC);
    step("bp.relC", 1'b0, 16'h0, 96'h0, 1'b1, 1'b0);

    // Flush in FULL with input offered
    step("ff.1", 1'b1, 16'h11, 96'h1111, 1'b0, 1'b0);
    step("ff.2", 1'b1, 16'h22, 96'h2222, 1'b0, 1'b0);
    step("ff.flush", 1'b1, 16'h33, 96'h3333, 1'b1, 1'b1);
    checkVal("ff.drop", 128'(drop_cnt), 128'd1);
    checkVal("ff.nop", 128'(out_data[31:0]), 128'h33);

    // Saturation of drop_cnt, then flushes while empty
    for (int i = 0; i < 300; i++) begin
      step("sat.push", 1'b1, 16'(i), 96'(i), 1'b0, 1'b0);
      step("sat.flush", 1'b0, 16'd0, 96'd0, 1'b0, 1'b1);
    end
    checkVal("sat.255", 128'(drop_cnt), 128'd255);
    for (int i = 0; i < 5; i++) step("sat.empty", 1'b0, 16'd0, 96'd0, 1'b0, 1'b1);
    checkVal("sat.hold", 128'(drop_cnt), 128'd255);

    // Mid-operation reset while FULL
    step("rst.1", 1'b1, 16'h44, 96'h4444, 1'b0, 1'b0);
    step("rst.2", 1'b1, 16'h55, 96'h5555, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    q.delete(); lastData = BUB; expDrop = 0;
    checkAll("rst.async");
    @(negedge clk) reset = 1'b1;
    step("rst.first", 1'b1, 16'h66, 96'h6666, 1'b1, 1'b0);
    checkVal("rst.lat1", 128'(out_data), 128'h6666);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step("rand", ($urandom_range(0, 99) < 70), 16'($urandom),
           {$urandom, $urandom, $urandom}, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numErrors);
    $finish;
  end

endmodule
